// File: rtl/phase_sweep_gen_pkg.sv
// rtl/phase_sweep_gen_pkg.sv - shared state encodings and constants for the phase sweep generator
//
// Purpose: FSM state type and the default pi constant in angle LSBs (pi * 2^14)
//          used by the top level and the rescale pipeline.
// Ports:   none (package).

package phase_sweep_gen_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   localparam int unsigned PI_Q_DEF = 51472;

endpackage

// File: rtl/phase_sweep_gen_angle_rescale.sv
// rtl/phase_sweep_gen_angle_rescale.sv - 2-stage rescale of an unsigned phase slice to a signed CORDIC angle
//
// Purpose: maps p in [0, 2^BITS) onto [-PI_Q, +PI_Q) as
//          angle = (p * PI_Q) >> (BITS-1) - PI_Q, with a valid bit carried alongside.
// Ports:   clk, rst      clock, asynchronous active-high reset
//          p_i           unsigned phase slice
//          vld_i         p_i is a live sample
//          angle_o       signed angle, two cycles after p_i
//          vld_o         vld_i delayed two cycles

module angle_rescale
   import phase_sweep_gen_pkg::*;
#(
   parameter int          BITS = 16,
   parameter int unsigned PI_Q = PI_Q_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [BITS-1:0]        p_i,
   input  logic                   vld_i,
   output logic signed [BITS:0]   angle_o,
   output logic                   vld_o
);

   localparam int MW = BITS + 16;
   localparam int EW = MW + 2;

   logic [MW-1:0]        m_q;
   logic [MW-1:0]        m_d;
   logic                 vld1_q;
   logic [EW-1:0]        m_ext;
   logic signed [BITS:0] angle_d;

   assign m_d   = MW'(p_i) * MW'(PI_Q);
   assign m_ext = EW'(m_q >> (BITS - 1));
   // Subtraction done wide, then truncated to the BITS+1 signed angle word.
   assign angle_d = (BITS+1)'(m_ext - EW'(PI_Q));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q     <= '0;
         vld1_q  <= 1'b0;
         angle_o <= '0;
         vld_o   <= 1'b0;
      end else begin
         m_q     <= m_d;
         vld1_q  <= vld_i;
         angle_o <= angle_d;
         vld_o   <= vld1_q;
      end
   end

endmodule

// File: rtl/phase_sweep_gen.sv
// rtl/phase_sweep_gen.sv - phase accumulator with linear frequency sweep feeding the CORDIC angle input
//
// Purpose: FSM (IDLE/RUN/FINISH) steps a frequency word every dwell+1 cycles,
//          accumulates phase, and rescales the top BITS of the accumulator to a
//          signed Q3.14 angle through a 2-stage pipeline.
// Ports:   clk, rst                 clock, asynchronous active-high reset
//          start, stop              run request pulse / abort (stop wins)
//          loop_en                  restart sweep at f_start after f_stop
//          f_start, f_step, f_stop  sweep frequency words
//          dwell                    extra cycles held per frequency
//          angle, angle_valid       signed angle and its valid flag
//          busy, done               FSM not idle / end-of-sweep pulse

module phase_sweep_gen
   import phase_sweep_gen_pkg::*;
#(
   parameter int          BITS  = 16,
   parameter int          ACC_W = 24,
   parameter int          DW_W  = 8,
   parameter int unsigned PI_Q  = PI_Q_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 stop,
   input  logic                 loop_en,
   input  logic [BITS-1:0]      f_start,
   input  logic [BITS-1:0]      f_step,
   input  logic [BITS-1:0]      f_stop,
   input  logic [DW_W-1:0]      dwell,
   output logic signed [BITS:0] angle,
   output logic                 angle_valid,
   output logic                 busy,
   output logic                 done
);

   state_e            state_q;
   logic [ACC_W-1:0]  acc_q;
   logic [BITS-1:0]   freq_q;
   logic [DW_W-1:0]   dwell_cnt_q;
   logic              busy_q;
   logic              done_q;

   // Latched configuration; live inputs are ignored while a run is in progress.
   logic [BITS-1:0]   f_start_q;
   logic [BITS-1:0]   f_step_q;
   logic [BITS-1:0]   f_stop_q;
   logic [DW_W-1:0]   dwell_q;
   logic              loop_q;

   logic [BITS:0]     freq_sum;
   logic [BITS-1:0]   freq_d;

   // One extra bit so the saturation compare sees the carry.
   always_comb begin
      freq_sum = {1'b0, freq_q} + {1'b0, f_step_q};
      freq_d   = freq_sum[BITS-1:0];
      if (freq_sum > {1'b0, f_stop_q}) begin
         freq_d = f_stop_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         freq_q      <= '0;
         dwell_cnt_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         f_start_q   <= '0;
         f_step_q    <= '0;
         f_stop_q    <= '0;
         dwell_q     <= '0;
         loop_q      <= 1'b0;
      end else if (stop) begin
         // Abort keeps the accumulator; the next start clears it.
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  f_start_q   <= f_start;
                  f_step_q    <= f_step;
                  f_stop_q    <= f_stop;
                  dwell_q     <= dwell;
                  loop_q      <= loop_en;
                  freq_q      <= f_start;
                  acc_q       <= '0;
                  dwell_cnt_q <= '0;
                  state_q     <= ST_RUN;
                  busy_q      <= 1'b1;
               end
            end
            ST_RUN: begin
               acc_q <= acc_q + ACC_W'(freq_q);
               if (dwell_cnt_q == dwell_q) begin
                  dwell_cnt_q <= '0;
                  if ((freq_q == f_stop_q) && (f_step_q != '0)) begin
                     if (loop_q) begin
                        // Reload frequency only; phase stays continuous.
                        freq_q <= f_start_q;
                     end else begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     freq_q <= freq_d;
                  end
               end else begin
                  dwell_cnt_q <= dwell_cnt_q + 1'b1;
               end
            end
            ST_FINISH: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;

   angle_rescale #(
      .BITS (BITS),
      .PI_Q (PI_Q)
   ) u_rescale (
      .clk     (clk),
      .rst     (rst),
      .p_i     (acc_q[ACC_W-1 -: BITS]),
      .vld_i   (state_q == ST_RUN),
      .angle_o (angle),
      .vld_o   (angle_valid)
   );

endmodule

// File: tb/tb_phase_sweep_gen.sv
// tb/tb_phase_sweep_gen.sv - directed self-checking bench for phase_sweep_gen

module tb_phase_sweep_gen;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               stop;
   logic               loop_en;
   logic [15:0]        f_start;
   logic [15:0]        f_step;
   logic [15:0]        f_stop;
   logic [7:0]         dwell;
   logic signed [16:0] angle;
   logic               angle_valid;
   logic               busy;
   logic               done;

   int total = 0;
   int bad   = 0;

   longint samp[$];
   int     cyc;
   int     first_v;
   int     last_v;
   int     done_cnt;
   int     done_cyc;
   int     busy_low_cyc;
   int     busy_hi_cnt;

   always #5 clk = ~clk;

   phase_sweep_gen #(
      .BITS  (16),
      .ACC_W (24),
      .DW_W  (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .stop        (stop),
      .loop_en     (loop_en),
      .f_start     (f_start),
      .f_step      (f_step),
      .f_stop      (f_stop),
      .dwell       (dwell),
      .angle       (angle),
      .angle_valid (angle_valid),
      .busy        (busy),
      .done        (done)
   );

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   // Expected angle for a 16-bit phase slice p.
   function automatic longint ang(input longint p);
      return ((p * 51472) >> 15) - 51472;
   endfunction

   task automatic clear_obs();
      samp.delete();
      cyc          = 0;
      first_v      = -1;
      last_v       = -1;
      done_cnt     = 0;
      done_cyc     = -1;
      busy_low_cyc = -1;
      busy_hi_cnt  = 0;
   endtask

   // Call at a negedge: drives config and a start pulse for the next edge.
   task automatic kick(input logic [15:0] fs, input logic [15:0] fp, input logic [15:0] fe,
                       input logic [7:0] dw, input logic lp);
      f_start = fs;
      f_step  = fp;
      f_stop  = fe;
      dwell   = dw;
      loop_en = lp;
      start   = 1'b1;
      clear_obs();
   endtask

   task automatic observe(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(negedge clk);
         start = 1'b0;
         cyc++;
         if (angle_valid) begin
            samp.push_back(longint'(angle));
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy) busy_hi_cnt++;
         else if (busy_low_cyc < 0) busy_low_cyc = cyc;
      end
   endtask

   task automatic stop_run(input string tag);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check({tag, "_busy_after_stop"}, longint'(busy), 0);
      repeat (2) @(negedge clk);
      check({tag, "_valid_after_stop"}, longint'(angle_valid), 0);
   endtask

   initial begin
      int     errs;
      longint acc;
      longint fq;

      rst = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      f_start = '0; f_step = '0; f_stop = '0; dwell = '0;
      clear_obs();
      repeat (2) @(negedge clk);
      check("rst_angle", longint'(angle), 0);
      check("rst_valid", longint'(angle_valid), 0);
      check("rst_busy",  longint'(busy), 0);
      check("rst_done",  longint'(done), 0);
      rst = 1'b0;
      observe(10);
      check("idle_busy_cnt", busy_hi_cnt, 0);
      check("idle_nsamp", samp.size(), 0);

      // Fixed tone at half scale: p steps by 0x80 per sample.
      kick(16'h8000, 16'h0000, 16'hFFFF, 8'd0, 1'b0);
      observe(520);
      check("tone_first_valid_cyc", first_v, 3);
      check("tone_nsamp", samp.size(), 518);
      check("tone_s0", samp[0], -51472);
      check("tone_s1", samp[1], -51271);
      check("tone_s256", samp[256], 0);
      check("tone_s512_wrap", samp[512], -51472);
      errs = 0;
      for (int k = 0; k < samp.size(); k++)
         if (samp[k] != ang((longint'(k) * 128) % 65536)) errs++;
      check("tone_ramp_errs", errs, 0);
      check("tone_done_cnt", done_cnt, 0);
      stop_run("tone");

      // Non-looping sweep, four frequencies held four cycles each.
      kick(16'h0100, 16'h0100, 16'h0400, 8'd3, 1'b0);
      observe(25);
      check("sweep_nsamp", samp.size(), 16);
      errs = 0;
      acc = 0;
      for (int k = 0; k < 16; k++) begin
         if (k < samp.size() && samp[k] != ang((acc >> 8) & 16'hFFFF)) errs++;
         fq  = 256 * (k / 4 + 1);
         acc = (acc + fq) % (64'd1 << 24);
      end
      check("sweep_ramp_errs", errs, 0);
      check("sweep_done_cnt", done_cnt, 1);
      check("sweep_done_cyc", done_cyc, 17);
      check("sweep_busy_low_cyc", busy_low_cyc, 18);
      check("sweep_first_valid", first_v, 3);
      check("sweep_last_valid", last_v, 18);

      // Looping sweep where the step overshoots f_stop and saturates.
      kick(16'h0100, 16'h0300, 16'h0200, 8'd0, 1'b1);
      observe(40);
      check("loop_nsamp", samp.size(), 38);
      errs = 0;
      acc = 0;
      for (int k = 0; k < samp.size(); k++) begin
         if (samp[k] != ang((acc >> 8) & 16'hFFFF)) errs++;
         fq  = (k % 2 == 0) ? 256 : 512;
         acc = (acc + fq) % (64'd1 << 24);
      end
      check("loop_ramp_errs", errs, 0);
      check("loop_done_cnt", done_cnt, 0);
      check("loop_busy", longint'(busy), 1);
      stop_run("loop");

      // Stop in the middle of a sweep: no done pulse.
      kick(16'h0100, 16'h0100, 16'h0400, 8'd3, 1'b0);
      observe(8);
      stop = 1'b1;
      observe(1);
      stop = 1'b0;
      observe(5);
      check("midstop_done_cnt", done_cnt, 0);
      check("midstop_busy_low_cyc", busy_low_cyc, 9);

      // start and stop together: stays idle.
      kick(16'h0100, 16'h0000, 16'hFFFF, 8'd0, 1'b0);
      stop = 1'b1;
      observe(1);
      stop = 1'b0;
      observe(4);
      check("startstop_busy_cnt", busy_hi_cnt, 0);
      check("startstop_nsamp", samp.size(), 0);

      // start while running is ignored; tone at 0x100 gives p = sample index.
      kick(16'h0100, 16'h0000, 16'hFFFF, 8'd0, 1'b0);
      observe(10);
      f_start = 16'h4000;
      dwell   = 8'd5;
      start   = 1'b1;
      observe(10);
      check("restart_nsamp", samp.size(), 18);
      check("rescale_p1", samp[1], -51471);
      errs = 0;
      for (int k = 0; k < samp.size(); k++)
         if (samp[k] != ang(k)) errs++;
      check("restart_ramp_errs", errs, 0);
      stop_run("restart");

      // Tone 0xFF00: sample 257 has p = 257*0xFF = 0xFFFF.
      kick(16'hFF00, 16'h0000, 16'hFFFF, 8'd0, 1'b0);
      observe(262);
      check("rescale_nsamp", samp.size(), 260);
      check("rescale_pmax", samp[257], 51470);
      stop_run("rescale");

      // Asynchronous reset in the middle of a run.
      kick(16'h8000, 16'h0000, 16'hFFFF, 8'd0, 1'b0);
      observe(6);
      #2 rst = 1'b1;
      #1;
      check("arst_angle", longint'(angle), 0);
      check("arst_valid", longint'(angle_valid), 0);
      check("arst_busy",  longint'(busy), 0);
      check("arst_done",  longint'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      clear_obs();
      observe(10);
      check("arst_idle_busy_cnt", busy_hi_cnt, 0);
      check("arst_idle_nsamp", samp.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
